hex_keypad_scan: RTL



---
 rtl/keypad_pkg.sv | 39 +++
 rtl/hex_keypad_scan_row_sync.sv | 24 ++
 rtl/hex_keypad_scan.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the hex keypad scanner.
package keypad_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        KIND_NONE   = 2'b00,
        KIND_SINGLE = 2'b01,
        KIND_MULTI  = 2'b10
    } kind_t;

    typedef enum logic {
        RELEASED = 1'b0,
        HELD     = 1'b1
    } state_t;

    // Number of rows reporting a closed switch in one column sample.
    function automatic logic [2:0] count_ones(input logic [3:0] bits);
        logic [2:0] total;
        total = 3'd0;
        for (int i = 0; i < 4; i++) begin
            total = total + 3'(bits[i]);
        end
        return total;
    endfunction

    // Row index of the lowest set bit; only meaningful when one bit is set.
    function automatic logic [1:0] onehot_index(input logic [3:0] bits);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bits[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hex_keypad_scan_row_sync.sv
// Two-flop synchronizer bringing the asynchronous row lines into the clock domain.
module row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta;

    // Both stages clear on reset so a re-scan after reset starts from idle rows.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            meta   <= '0;
            synced <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/hex_keypad_scan.sv
// 4x4 hex keypad scanner: column strobe, per-scan classification, debounce and press reporting.
module hex_keypad_scan #(
    parameter int SCAN_DIV       = 1024,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    output logic [3:0]  o_Cols,
    input  logic [3:0]  i_Rows,
    output logic [3:0]  o_Key,
    output logic        o_Key_DV,
    output logic [15:0] o_Value,
    output logic        o_Held
);

    import keypad_pkg::*;

    localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  STABLE_MAX = 4'(DEBOUNCE_SCANS);

    logic [3:0]       rows_sync;
    logic [15:0]      dwell;
    logic [1:0]       col_idx;
    logic             sample_now;
    logic             scan_end;

    kind_t            acc_kind;
    logic [KEY_W-1:0] acc_code;
    kind_t            merge_kind;
    logic [KEY_W-1:0] merge_code;

    kind_t            prev_kind;
    logic [KEY_W-1:0] prev_code;
    logic [3:0]       stable_cnt;
    logic [3:0]       stable_next;
    logic             result_same;

    state_t           state;
    state_t           next_state;
    logic             accept;

    row_sync #(.WIDTH(4)) u_row_sync (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .raw    (i_Rows),
        .synced (rows_sync)
    );

    assign sample_now = (dwell == DWELL_LAST);
    assign scan_end   = sample_now && (col_idx == 2'd3);
    assign o_Held     = (state == HELD);

    // Dwell on each column, then rotate the one-hot strobe after its sample.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            dwell   <= 16'd0;
            col_idx <= 2'd0;
            o_Cols  <= 4'b0001;
        end else if (sample_now) begin
            dwell   <= 16'd0;
            col_idx <= col_idx + 2'd1;
            o_Cols  <= {o_Cols[2:0], o_Cols[3]};
        end else begin
            dwell <= dwell + 16'd1;
        end
    end

    // Fold the current column's rows into the running scan classification.
    always_comb begin
        merge_kind = acc_kind;
        merge_code = acc_code;
        if (rows_sync != 4'd0) begin
            if ((acc_kind == KIND_NONE) && (count_ones(rows_sync) == 3'd1)) begin
                merge_kind = KIND_SINGLE;
                merge_code = {onehot_index(rows_sync), col_idx};
            end else begin
                merge_kind = KIND_MULTI;
                merge_code = '0;
            end
        end
    end

    // Per-scan accumulator, cleared once the last column has been folded in.
    always_ff @(posedge i_Clk) begin
        if (i_Rst || scan_end) begin
            acc_kind <= KIND_NONE;
            acc_code <= '0;
        end else if (sample_now) begin
            acc_kind <= merge_kind;
            acc_code <= merge_code;
        end
    end

    // Stable-count update: repeat of the previous scan result counts up, anything new restarts at 1.
    always_comb begin
        result_same = (merge_kind == prev_kind) && (merge_code == prev_code);
        stable_next = 4'd1;
        if (result_same) begin
            stable_next = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 4'd1;
        end
    end

    // Remember the last full-scan result and how many times in a row it was seen.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            prev_kind  <= KIND_NONE;
            prev_code  <= '0;
            stable_cnt <= 4'd0;
        end else if (scan_end) begin
            stable_cnt <= stable_next;
            if (!result_same) begin
                prev_kind <= merge_kind;
                prev_code <= merge_code;
            end
        end
    end

    // Press/release decision, only on a scan end whose result is fully debounced.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        if (scan_end && (stable_next == STABLE_MAX)) begin
            case (state)
                RELEASED: begin
                    if (merge_kind == KIND_SINGLE) begin
                        accept     = 1'b1;
                        next_state = HELD;
                    end
                end
                HELD: begin
                    if (merge_kind == KIND_NONE) begin
                        next_state = RELEASED;
                    end
                end
                default: next_state = RELEASED;
            endcase
        end
    end

    // State register plus the registered key outputs, all updating on the accepting edge.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state    <= RELEASED;
            o_Key_DV <= 1'b0;
            o_Key    <= '0;
            o_Value  <= 16'h0000;
        end else begin
            state    <= next_state;
            o_Key_DV <= accept;
            if (accept) begin
                o_Key   <= merge_code;
                o_Value <= {o_Value[11:0], merge_code};
            end
        end
    end

endmodule
